// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - byte-stream frame collector with four-phase hand-off to stage 2
module frame_loader #(
  parameter int N_BYTES     = 192,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              data_rdy,
  output logic              we_b,
  output logic [ADDR_W-1:0] dir_B,
  output logic [7:0]        din_B,
  output logic              data_done,
  output logic              busy,
  output logic              overrun,
  output logic              frame_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  // Abort fires on the edge where the idle count would reach TIMEOUT_CYC-1,
  // so frame_err lands exactly TIMEOUT_CYC cycles after the last strobe.
  localparam logic [TMO_W-1:0]  TMO_FIRE  = TMO_W'(TIMEOUT_CYC - 2);
  localparam logic [TMO_W-1:0]  TMO_SAT   = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_RELEASE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              last_byte, tmo_hit;

  logic              we_q, data_done_q, busy_q, overrun_q, frame_err_q;
  logic [ADDR_W-1:0] dir_q;
  logic [7:0]        din_q;

  // Next-value helpers: saturating idle count and a byte index that never wraps
  always_comb begin
    tmo_d     = (tmo_q == TMO_SAT) ? tmo_q : tmo_q + TMO_W'(1);
    last_byte = (cnt_q == LAST_ADDR);
    cnt_d     = last_byte ? cnt_q : cnt_q + ADDR_W'(1);
    tmo_hit   = (tmo_q == TMO_FIRE);
  end

  // Control FSM; every output is a register updated here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      we_q        <= 1'b0;
      dir_q       <= '0;
      din_q       <= '0;
      data_done_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      we_q        <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tmo_q <= '0;
          if (rx_valid) begin
            we_q      <= 1'b1;
            dir_q     <= '0;
            din_q     <= rx_data;
            overrun_q <= 1'b0;
            busy_q    <= 1'b1;
            if (N_BYTES == 1) begin
              cnt_q   <= '0;
              state_q <= S_DONE;
            end else begin
              cnt_q   <= ADDR_W'(1);
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (rx_valid) begin
            we_q  <= 1'b1;
            dir_q <= cnt_q;
            din_q <= rx_data;
            tmo_q <= '0;
            cnt_q <= cnt_d;
            if (last_byte) begin
              state_q <= S_DONE;
            end
          end else if (tmo_hit) begin
            // Truncated frame: drop back to IDLE, leave the buffer untouched
            frame_err_q <= 1'b1;
            cnt_q       <= '0;
            tmo_q       <= '0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        S_DONE: begin
          if (rx_valid) begin
            overrun_q <= 1'b1;
          end
          // Only an acknowledge seen while data_done is already up counts
          if (data_done_q && data_rdy) begin
            data_done_q <= 1'b0;
            state_q     <= S_RELEASE;
          end else begin
            data_done_q <= 1'b1;
          end
        end
        S_RELEASE: begin
          if (rx_valid) begin
            overrun_q <= 1'b1;
          end
          if (!data_rdy) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign we_b      = we_q;
  assign dir_B     = dir_q;
  assign din_B     = din_q;
  assign data_done = data_done_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
